// File: rtl/ovl_win_arbiter_if.sv
// Bus between the requesters and ovl_win_arbiter, plus the checker-facing outputs.
// The master side drives requests. The slave side (the arbiter) returns grants and window pulses.
interface ovl_win_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 4,
   parameter int CNT_W   = 8
);

   logic                       enable;
   logic [NUM_REQ-1:0]         req;
   logic [NUM_REQ*WIDTH-1:0]   req_expr;
   logic [NUM_REQ*CNT_W-1:0]   req_len;

   logic [NUM_REQ-1:0]         gnt;
   logic                       start_event;
   logic                       end_event;
   logic [WIDTH-1:0]           test_expr;
   logic                       busy;
   logic [NUM_REQ-1:0]         done;

   modport master (
      output enable,
      output req,
      output req_expr,
      output req_len,
      input  gnt,
      input  start_event,
      input  end_event,
      input  test_expr,
      input  busy,
      input  done
   );

   modport slave (
      input  enable,
      input  req,
      input  req_expr,
      input  req_len,
      output gnt,
      output start_event,
      output end_event,
      output test_expr,
      output busy,
      output done
   );

endinterface

// File: rtl/ovl_win_arbiter.sv
// ovl_win_arbiter: shares one ovl_win_unchange checker among NUM_REQ requesters.
// Requesters are granted round-robin. The winner's expression is muxed onto test_expr, and the
// window is bracketed with start_event and end_event.
// Optional feature: define OVL_WIN_ARB_STATS_EN to add a saturating win_count output.
module ovl_win_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 4,
   parameter int CNT_W   = 8
) (
   input  logic                 clock,
   input  logic                 reset,
   ovl_win_arbiter_if.slave     bus
`ifdef OVL_WIN_ARB_STATS_EN
   ,
   output logic [15:0]          win_count
`endif
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_START  = 2'd1;
   localparam logic [1:0] ST_WINDOW = 2'd2;
   localparam logic [1:0] ST_END    = 2'd3;

   logic [1:0]          state_q,  state_d;
   logic [NUM_REQ-1:0]  gnt_q,    gnt_d;
   logic [CNT_W-1:0]    cnt_q,    cnt_d;
   logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;

   logic                win_found;
   logic [PTR_W-1:0]    win_idx;
   logic [PTR_W-1:0]    gnt_idx;
   logic [WIDTH-1:0]    expr_mux;

   // Round-robin search: the first set request bit starting at rr_ptr and wrapping around.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!win_found && bus.req[(int'(rr_ptr_q) + k) % NUM_REQ]) begin
            win_found = 1'b1;
            win_idx   = PTR_W'((int'(rr_ptr_q) + k) % NUM_REQ);
         end
      end
   end

   // Binary index of the current one-hot grant, used to advance the pointer.
   always_comb begin
      gnt_idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt_q[i]) begin
            gnt_idx = PTR_W'(i);
         end
      end
   end

   // Live pass-through of the granted requester's expression; zero when nobody holds the grant.
   always_comb begin
      expr_mux = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt_q[i]) begin
            expr_mux = expr_mux | bus.req_expr[i*WIDTH +: WIDTH];
         end
      end
   end

   // Window sequencing: grant in IDLE, one START cycle, count down len cycles, then one END cycle.
   always_comb begin
      state_d  = state_q;
      gnt_d    = gnt_q;
      cnt_d    = cnt_q;
      rr_ptr_d = rr_ptr_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.enable && win_found) begin
               state_d          = ST_START;
               gnt_d            = '0;
               gnt_d[win_idx]   = 1'b1;
               cnt_d            = bus.req_len[int'(win_idx)*CNT_W +: CNT_W];
            end
         end
         ST_START: begin
            if (cnt_q == '0) begin
               state_d = ST_END;
            end else begin
               state_d = ST_WINDOW;
            end
         end
         ST_WINDOW: begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
               state_d = ST_END;
            end
         end
         ST_END: begin
            state_d = ST_IDLE;
            gnt_d   = '0;
            cnt_d   = '0;
            if (int'(gnt_idx) == NUM_REQ - 1) begin
               rr_ptr_d = '0;
            end else begin
               rr_ptr_d = gnt_idx + 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            gnt_d   = '0;
            cnt_d   = '0;
         end
      endcase
   end

   // State registers. A reset in the middle of a window abandons it without an end_event.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         gnt_q    <= '0;
         cnt_q    <= '0;
         rr_ptr_q <= '0;
      end else begin
         state_q  <= state_d;
         gnt_q    <= gnt_d;
         cnt_q    <= cnt_d;
         rr_ptr_q <= rr_ptr_d;
      end
   end

   assign bus.gnt         = gnt_q;
   assign bus.start_event = (state_q == ST_START);
   assign bus.end_event   = (state_q == ST_END);
   assign bus.busy        = (state_q != ST_IDLE);
   assign bus.done        = (state_q == ST_END) ? gnt_q : '0;
   assign bus.test_expr   = expr_mux;

`ifdef OVL_WIN_ARB_STATS_EN
   logic [15:0] win_count_q, win_count_d;

   // Count completed windows, holding at all-ones rather than wrapping.
   always_comb begin
      win_count_d = win_count_q;
      if ((state_q == ST_END) && (win_count_q != 16'hFFFF)) begin
         win_count_d = win_count_q + 16'd1;
      end
   end

   // Window-count register, cleared by reset.
   always_ff @(posedge clock) begin
      if (!reset) begin
         win_count_q <= '0;
      end else begin
         win_count_q <= win_count_d;
      end
   end

   assign win_count = win_count_q;
`endif

endmodule

// File: tb/tb_ovl_win_arbiter.sv
// Self-checking bench for ovl_win_arbiter. The reference model reasons in window timestamps
// (grant cycle, start cycle, end cycle) rather than in arbiter states.
module tb_ovl_win_arbiter;

   localparam int NR = 4;
   localparam int W  = 4;
   localparam int CW = 8;

   logic clock;
   logic reset;

   ovl_win_arbiter_if #(.NUM_REQ(NR), .WIDTH(W), .CNT_W(CW)) bus ();

`ifdef OVL_WIN_ARB_STATS_EN
   logic [15:0] win_count;
`endif

   ovl_win_arbiter #(.NUM_REQ(NR), .WIDTH(W), .CNT_W(CW)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
`ifdef OVL_WIN_ARB_STATS_EN
      ,
      .win_count (win_count)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int checks   = 0;
   int failures = 0;

   // Reference model: the current window is [mStart, mEnd] owned by mOwner.
   int          cyc        = 0;
   bit          modelValid = 1'b0;
   int          mPtr       = 0;
   int          mOwner     = 0;
   int          mStart     = -100;
   int          mEnd       = -100;
   int          mWins      = 0;
   logic [NR*W-1:0] curExpr = '0;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, observed, expected);
      end
   endtask

   task automatic checkCycle();
      logic          active;
      logic [NR-1:0] expGnt;
      logic [W-1:0]  expExpr;
      active  = (cyc >= mStart) && (cyc <= mEnd);
      expGnt  = active ? (NR'(1) << mOwner) : '0;
      expExpr = '0;
      if (active) begin
         expExpr = curExpr[mOwner*W +: W];
      end
      checkOutput("gnt",         32'(bus.gnt),         32'(expGnt));
      checkOutput("busy",        32'(bus.busy),        32'(active));
      checkOutput("start_event", 32'(bus.start_event), 32'(cyc == mStart));
      checkOutput("end_event",   32'(bus.end_event),   32'(cyc == mEnd));
      checkOutput("done",        32'(bus.done),        (cyc == mEnd) ? 32'(expGnt) : 32'd0);
      checkOutput("test_expr",   32'(bus.test_expr),   32'(expExpr));
`ifdef OVL_WIN_ARB_STATS_EN
      checkOutput("win_count",   32'(win_count),       32'(mWins));
`endif
   endtask

   // What the clock edge that closes cycle cyc does, in window-schedule terms.
   task automatic modelEdge(input logic rst, input logic en, input logic [NR-1:0] rq, input logic [NR*CW-1:0] ln);
      int len;
      if (!rst) begin
         modelValid = 1'b1;
         mPtr   = 0;
         mStart = -100;
         mEnd   = -100;
         mWins  = 0;
      end else if (modelValid) begin
         if (cyc == mEnd && mWins < 65535) begin
            mWins++;
         end
         if (cyc > mEnd && en && (rq != '0)) begin
            for (int k = 0; k < NR; k++) begin
               if (rq[(mPtr + k) % NR]) begin
                  mOwner = (mPtr + k) % NR;
                  break;
               end
            end
            len    = int'(ln[mOwner*CW +: CW]);
            mStart = cyc + 1;
            mEnd   = cyc + 2 + len;
            mPtr   = (mOwner + 1) % NR;
         end
      end
   endtask

   task automatic applyStimulus(input logic rst, input logic en, input logic [NR-1:0] rq,
                                input logic [NR*W-1:0] ex, input logic [NR*CW-1:0] ln);
      @(negedge clock);
      reset        = rst;
      bus.enable   = en;
      bus.req      = rq;
      bus.req_expr = ex;
      bus.req_len  = ln;
      curExpr      = ex;
      #1;
      if (modelValid) begin
         checkCycle();
      end
      modelEdge(rst, en, rq, ln);
      cyc++;
   endtask

   function automatic logic [NR*CW-1:0] randLens();
      logic [NR*CW-1:0] l;
      l = '0;
      for (int i = 0; i < NR; i++) begin
         if ($urandom_range(0, 49) == 0) begin
            l[i*CW +: CW] = 8'hFF;
         end else begin
            l[i*CW +: CW] = CW'($urandom_range(0, 6));
         end
      end
      return l;
   endfunction

   initial begin
      reset        = 1'b0;
      bus.enable   = 1'b0;
      bus.req      = '0;
      bus.req_expr = '0;
      bus.req_len  = '0;

      repeat (3) applyStimulus(1'b0, 1'b0, 4'b0000, 16'h0000, 32'h0);

      // Single requester, len 3, expression held at 0101.
      repeat (10) applyStimulus(1'b1, 1'b1, 4'b0001, 16'h0005, 32'h0000_0003);
      repeat (3)  applyStimulus(1'b1, 1'b1, 4'b0000, 16'h0005, 32'h0000_0003);

      // All requesting with len 0: grants rotate 0,1,2,3,0...
      repeat (20) applyStimulus(1'b1, 1'b1, 4'b1111, 16'h4321, 32'h0);
      repeat (3)  applyStimulus(1'b1, 1'b1, 4'b0000, 16'h4321, 32'h0);

      // Requester 1, len 2, its expression changes mid-window.
      repeat (2) applyStimulus(1'b1, 1'b1, 4'b0010, 16'h0030, 32'h0000_0200);
      repeat (6) applyStimulus(1'b1, 1'b1, 4'b0000, 16'h0040, 32'h0000_0200);

      // Reset in the middle of a len 5 window.
      applyStimulus(1'b1, 1'b1, 4'b0001, 16'h000A, 32'h0000_0005);
      repeat (2) applyStimulus(1'b1, 1'b1, 4'b0000, 16'h000A, 32'h0000_0005);
      applyStimulus(1'b0, 1'b1, 4'b0000, 16'h000A, 32'h0000_0005);
      repeat (8) applyStimulus(1'b1, 1'b1, 4'b0000, 16'h000A, 32'h0000_0005);

      // Enable low blocks grants. Dropping enable mid-window lets that window finish.
      repeat (6)  applyStimulus(1'b1, 1'b0, 4'b0010, 16'h00F0, 32'h0000_0100);
      applyStimulus(1'b1, 1'b1, 4'b0100, 16'h0900, 32'h0004_0000);
      repeat (12) applyStimulus(1'b1, 1'b0, 4'b0100, 16'h0900, 32'h0004_0000);

      // Longest window, len 255.
      applyStimulus(1'b1, 1'b1, 4'b0100, 16'h0C00, 32'h00FF_0000);
      repeat (262) applyStimulus(1'b1, 1'b1, 4'b0000, 16'h0C00, 32'h00FF_0000);

      // Randomized traffic with occasional resets.
      for (int n = 0; n < 3000; n++) begin
         applyStimulus(logic'($urandom_range(0, 199) != 0),
                       logic'($urandom_range(0, 9) != 0),
                       NR'($urandom),
                       (NR*W)'($urandom),
                       randLens());
      end

`ifdef OVL_WIN_ARB_STATS_EN
      // Five windows from reset, then saturation from an all-ones count.
      applyStimulus(1'b0, 1'b0, 4'b0000, 16'h0, 32'h0);
      repeat (15) applyStimulus(1'b1, 1'b1, 4'b0001, 16'h1, 32'h0);
      repeat (3)  applyStimulus(1'b1, 1'b1, 4'b0000, 16'h1, 32'h0);
      checkOutput("win_count_five", 32'(win_count), 32'd5);
      force dut.win_count_q = 16'hFFFF;
      #1;
      release dut.win_count_q;
      mWins = 65535;
      repeat (6) applyStimulus(1'b1, 1'b1, 4'b0010, 16'h2, 32'h0);
      checkOutput("win_count_sat", 32'(win_count), 32'h0000FFFF);
`endif

      repeat (3) applyStimulus(1'b1, 1'b0, 4'b0000, 16'h0, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
